// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl
//
// Drives a 4-digit multiplexed seven-segment display from the processor's
// 13-bit debug value. The value is sampled once per scan frame. A sequential
// double-dabble engine converts it to BCD at one bit per clock. The four
// digits are then time-multiplexed onto the shared segment bus, and leading
// zeros are blanked.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit stays lit (must be >= 4)
//
// Ports
//   clk      in   system clock, rising-edge active
//   rst      in   asynchronous, active-low reset
//   ssd_val  in   13-bit unsigned value to display (0..8191)
//   anode    out  active-low one-hot digit enables, bit 0 = ones digit
//   seg      out  active-low segments {g,f,e,d,c,b,a}
//   bcd      out  last completed conversion {thousands,hundreds,tens,ones}
//   busy     out  high while the converter is shifting
// ---------------------------------------------------------------------------
module ssd_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] ssd_val,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic [15:0] bcd,
  output logic        busy
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Converter state
  state_t      state_q, state_d;
  logic [12:0] sreg_q, sreg_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bcd_q, bcd_d;
  logic        start_pending_q, start_pending_d;

  // Scan state
  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]       digit_q, digit_d;

  // Registered display outputs
  logic [3:0] anode_q, anode_d;
  logic [6:0] seg_q, seg_d;

  // Helper signals
  logic        frame_tick;
  logic        trigger;
  logic [15:0] acc_adj;
  logic [28:0] shifted;
  logic [3:0]  nibble;
  logic        blank;

  // Double-dabble correction: any BCD nibble of 5 or more gets 3 added, so
  // the following left shift carries it correctly into the next decade.
  function automatic logic [3:0] add3(input logic [3:0] n);
    if (n >= 4'd5) begin
      return n + 4'd3;
    end
    return n;
  endfunction

  // Active-low segment patterns {g,f,e,d,c,b,a}. Codes above 9 cannot come
  // out of the converter and show as dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign frame_tick = (refresh_q == CNT_LAST);

  // A new sample is taken once after reset. After that, one sample is taken
  // at the end of the last digit slot of every frame. A frame is at least
  // 16 cycles and a conversion takes 14, so the converter is always idle by
  // the time the next trigger arrives.
  assign trigger = start_pending_q ||
                   (frame_tick && (digit_q == 2'd3) && (state_q == IDLE));

  assign acc_adj = {add3(acc_q[15:12]), add3(acc_q[11:8]),
                    add3(acc_q[7:4]),   add3(acc_q[3:0])};

  // One double-dabble step: the corrected accumulator and the remaining
  // binary bits shift left together. The top accumulator bit falls off; it
  // is always zero for inputs up to 8191.
  assign shifted = {acc_adj, sreg_q} << 1;

  // Converter next-state logic. The visible bcd register is loaded only on
  // the final shift, so the display never shows a partial conversion.
  always_comb begin
    state_d         = state_q;
    sreg_d          = sreg_q;
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    bcd_d           = bcd_q;
    start_pending_d = start_pending_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          sreg_d          = ssd_val;
          acc_d           = 16'h0000;
          cnt_d           = 4'd13;
          start_pending_d = 1'b0;
          state_d         = SHIFT;
        end
      end
      SHIFT: begin
        acc_d  = shifted[28:13];
        sreg_d = shifted[12:0];
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          bcd_d   = shifted[28:13];
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Refresh counter and digit index. The digit advances on the counter's
  // terminal count and wraps from the thousands slot back to the ones slot.
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    digit_d   = digit_q;
    if (frame_tick) begin
      refresh_d = '0;
      digit_d   = digit_q + 2'd1;
    end
  end

  // Digit select, leading-zero blanking and segment decode. The result is
  // registered, so the outputs trail digit_q and bcd_q by one cycle. A slot
  // is blanked only when it and every more significant nibble are zero, so
  // inner zeros such as the ones in 1005 stay lit. The ones digit is never
  // blanked.
  always_comb begin
    nibble  = 4'h0;
    blank   = 1'b0;
    anode_d = 4'b1111;
    seg_d   = 7'b1111111;

    case (digit_q)
      2'd0: begin
        nibble = bcd_q[3:0];
        blank  = 1'b0;
      end
      2'd1: begin
        nibble = bcd_q[7:4];
        blank  = (bcd_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble = bcd_q[11:8];
        blank  = (bcd_q[15:8] == 8'h00);
      end
      default: begin
        nibble = bcd_q[15:12];
        blank  = (bcd_q[15:12] == 4'h0);
      end
    endcase

    if (!blank) begin
      anode_d = ~(4'b0001 << digit_q);
      seg_d   = seg_decode(nibble);
    end
  end

  // All state registers. Reset blanks the display, clears the result and
  // arms start_pending, so a fresh sample is taken right after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      sreg_q          <= 13'h0000;
      acc_q           <= 16'h0000;
      cnt_q           <= 4'd0;
      bcd_q           <= 16'h0000;
      start_pending_q <= 1'b1;
      refresh_q       <= '0;
      digit_q         <= 2'd0;
      anode_q         <= 4'b1111;
      seg_q           <= 7'b1111111;
    end else begin
      state_q         <= state_d;
      sreg_q          <= sreg_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      bcd_q           <= bcd_d;
      start_pending_q <= start_pending_d;
      refresh_q       <= refresh_d;
      digit_q         <= digit_d;
      anode_q         <= anode_d;
      seg_q           <= seg_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign bcd   = bcd_q;
  assign busy  = (state_q == SHIFT);

endmodule
